// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. A clock-enable divider paces the pixel
// position; every timing output is registered and updates on the same pixel tick.
module vga_timing_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          CLK100M,
  input  logic          RST_N,
  input  logic          EN,
  output logic          PIX_CE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          VDE,
  output logic          HS,
  output logic          VS,
  output logic          LINE_START,
  output logic          FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  // One extra bit so a sync end equal to 2^CW still compares correctly.
  localparam logic [CW:0]   H_VIS    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   HS_BEG   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_VIS    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   VS_BEG   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (DIV < 1 || CW < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] pos_h_q, pos_v_q, h_nxt, v_nxt;
  logic          tick;
  logic          pix_ce_q, vde_q, hs_q, vs_q, ls_q, fs_q;
  logic [CW-1:0] hcnt_q, vcnt_q;

  // NOTE: asserts asynchronously, releases two clocks later so no flop sees a
  // reset edge that races the clock.
  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    div_d = div_q;
    v_nxt = pos_v_q;
    tick  = EN && (div_q == DIV_LAST);
    if (EN) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_nxt = (pos_h_q == H_LAST) ? '0 : pos_h_q + 1'b1;
    if (pos_h_q == H_LAST) v_nxt = (pos_v_q == V_LAST) ? '0 : pos_v_q + 1'b1;
  end

  // Position resets to the last pixel of the frame so the first tick lands on (0,0).
  always_ff @(posedge CLK100M or negedge rst_int_n) begin
    // NOTE: state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_int_n) begin
      div_q    <= '0;
      pos_h_q  <= H_LAST;
      pos_v_q  <= V_LAST;
      pix_ce_q <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      vde_q    <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= tick;
      if (tick) begin
        pos_h_q <= h_nxt;
        pos_v_q <= v_nxt;
        hcnt_q  <= h_nxt;
        vcnt_q  <= v_nxt;
        vde_q   <= ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
        hs_q    <= (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END)) ? HS_POL : ~HS_POL;
        vs_q    <= (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END)) ? VS_POL : ~VS_POL;
        ls_q    <= (h_nxt == '0);
        fs_q    <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

  assign PIX_CE      = pix_ce_q;
  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign VDE         = vde_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA timing path. It derives a pixel clock-enable from the single system clock using an integer divider, in place of a derived clock. It generates registered horizontal and vertical counters, display enable, sync outputs with programmable polarity, and line/frame start strobes. The timing and divider are set by parameters, so the same block covers other modes. It feeds the pixel colour generator and the VGA output muxing in the video top level.

Parameters:
DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
HS_POL, 0, active level of HS (0 = active-low).
VS_POL, 0, active level of VS.
CW, 11, counter width; H_TOTAL and V_TOTAL must each be <= 2^CW.

Ports:
CLK100M  input  1  system clock, the only clock.
RST_N  input  1  asynchronous active-low reset.
EN  input  1  run enable; low freezes the divider, counters and all outputs.
PIX_CE  output  1  one-cycle pixel enable, high every DIV-th clock while EN=1.
HCNT  output  CW  current pixel column, 0..H_TOTAL-1.
VCNT  output  CW  current line, 0..V_TOTAL-1.
VDE  output  1  high when HCNT<H_ACTIVE and VCNT<V_ACTIVE.
HS  output  1  horizontal sync.
VS  output  1  vertical sync.
LINE_START  output  1  high for the whole pixel period where HCNT=0.
FRAME_START  output  1  high for the whole pixel period where HCNT=0 and VCNT=0.

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider:
  - Counter runs 0..DIV-1 and advances each clock while EN=1.
  - PIX_CE is registered and is high in the cycle after the divider reaches DIV-1.
  - With DIV=1, PIX_CE is constantly high while EN=1.
- Position update:
  - Position advances on each clock where the internal enable fires.
  - HCNT, VCNT, VDE, HS, VS, LINE_START and FRAME_START are all registered and change together in the same cycle; they are mutually consistent with zero skew.
- Horizontal wrap: HCNT=H_TOTAL-1 wraps to 0.
- Vertical step and wrap:
  - VCNT increments in the same cycle that HCNT wraps.
  - VCNT=V_TOTAL-1 together with HCNT wrap gives VCNT=0. This simultaneous line and frame wrap occurs in a single update.
- HS is at level HS_POL when H_ACTIVE+H_FP <= HCNT < H_ACTIVE+H_FP+H_SYNC, otherwise at ~HS_POL.
- VS is at level VS_POL when V_ACTIVE+V_FP <= VCNT < V_ACTIVE+V_FP+V_SYNC, over whole lines, otherwise at ~VS_POL.
- Reset values (asynchronous, RST_N=0):
  - Outputs: PIX_CE=0, HCNT=0, VCNT=0, VDE=0, HS=~HS_POL, VS=~VS_POL, LINE_START=0, FRAME_START=0.
  - Internal: divider=0; internal position = (H_TOTAL-1, V_TOTAL-1).
  - Consequence: the first pixel update after reset presents (0,0) with VDE=1 and LINE_START=FRAME_START=1.
- EN=0: divider and position hold and PIX_CE=0. All other outputs hold their last values. Resuming continues exactly where it stopped, with no skipped or repeated pixel.
- Reset asserted mid-frame: all outputs return to their reset values immediately. After release, timing restarts at the frame start.
- Release of RST_N is synchronised internally with a 2-flop sync, so outputs start 2 clocks after release.
- Illegal parameters (any width 0, DIV 0, totals > 2^CW): elaboration error via a generate-time check.

Test Plan:
- Reset, then release with EN=1 and defaults -> all outputs at reset values during reset. First PIX_CE arrives within DIV+2 clocks, with HCNT=0, VCNT=0, VDE=1, FRAME_START=1, HS=VS=1.
- Free-run one line -> PIX_CE period is exactly 4 clocks. VDE drops at HCNT=640. HS is low for HCNT 656..751 (96 pixels = 384 clocks). HCNT wraps 799->0 with VCNT 0->1 and LINE_START=1.
- Free-run one full frame -> VS is low exactly for VCNT 490..491. At (799,524) the next update gives (0,0) with FRAME_START=1. The frame is 800*525*4 = 1,680,000 clocks.
- Drop EN for 37 clocks mid-line at HCNT=100 -> PIX_CE=0 and all outputs are frozen. After EN returns, the next update gives HCNT=101.
- Assert RST_N=0 asynchronously at VCNT=300 -> outputs reach reset values without waiting for a clock edge. The restart begins at (0,0).
- Small config: DIV=1, H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1 -> PIX_CE constantly high. HS is high for HCNT 5..6 in an 8-pixel line. VS is high on line 4 of a 6-line frame.
